// File: rtl/disk_nib_stream.sv
// disk_nib_stream
// ----------------------------------------------------------------------------
// Rotating-disk emulation for one NIB track held in an external buffer.
// Presents one track byte per disk byte-time to the Disk II controller and
// wraps continuously like a spinning track. Rotation freezes while the motor
// is off or while the track loader is filling the buffer.
//
// Optional write-back path: define DISK_WRITE_EN to let the controller write
// bytes into the buffer at the head position (and flag the track dirty).
// Without it the block is read-only and the write-side inputs are ignored.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   motor_on   in   drive motor running
//   load_busy  in   track loader busy; rotation frozen
//   ram_addr   out  track buffer address (always equals pos)
//   ram_dout   in   track buffer read data (1-cycle read latency)
//   ram_din    out  track buffer write data
//   ram_we     out  track buffer write strobe (one-cycle pulse)
//   rd_data    out  latched disk byte, bit7 = byte ready
//   rd_ack     in   controller consumed rd_data (clears bit7)
//   wr_mode    in   controller in write mode
//   wr_data    in   byte from controller data latch
//   wr_load    in   strobe capturing wr_data
//   pos        out  current byte position
//   dirty      out  buffer modified since last dirty_clr
//   dirty_clr  in   clear dirty
// ----------------------------------------------------------------------------
module disk_nib_stream #(
    parameter int unsigned TRACK_LEN   = 6656,
    parameter int unsigned BYTE_CYCLES = 458,
    parameter int unsigned AW          = 13
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          motor_on,
    input  logic          load_busy,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_dout,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    output logic [7:0]    rd_data,
    input  logic          rd_ack,
    input  logic          wr_mode,
    input  logic [7:0]    wr_data,
    input  logic          wr_load,
    output logic [AW-1:0] pos,
    output logic          dirty,
    input  logic          dirty_clr
);

    localparam int unsigned DW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SPIN, FETCH, LATCH} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic          run;
    logic          at_end;
    logic [AW-1:0] pos_next;

    assign run      = motor_on & ~load_busy;
    assign at_end   = (div == DW'(BYTE_CYCLES - 1));
    assign pos_next = (pos == AW'(TRACK_LEN - 1)) ? '0 : pos + 1'b1;
    assign ram_addr = pos;

`ifdef DISK_WRITE_EN
    logic       wr_pend;
    logic [7:0] wr_buf;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_mode, wr_data, wr_load, dirty_clr};
    assign ram_we    = 1'b0;
    assign ram_din   = '0;
    assign dirty     = 1'b0;
`endif

    // The divider runs in every state while rotation is enabled, so the
    // FETCH/LATCH access never stretches the byte period. BYTE_CYCLES >= 4
    // guarantees the divider cannot reach its terminal count in FETCH/LATCH.
    // Later non-blocking assignments in the LATCH branch override the
    // earlier rd_ack / wr_load / dirty_clr updates, giving the new byte,
    // the write and the dirty set priority.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div     <= '0;
            pos     <= '0;
            rd_data <= '0;
`ifdef DISK_WRITE_EN
            ram_we  <= 1'b0;
            ram_din <= '0;
            dirty   <= 1'b0;
            wr_pend <= 1'b0;
            wr_buf  <= '0;
`endif
        end else begin
            if (run) begin
                div <= at_end ? '0 : div + 1'b1;
            end

            if (rd_ack) begin
                rd_data[7] <= 1'b0;
            end

`ifdef DISK_WRITE_EN
            ram_we <= 1'b0;
            if (wr_load) begin
                wr_buf  <= wr_data;
                wr_pend <= 1'b1;
            end
            if (dirty_clr) begin
                dirty <= 1'b0;
            end
`endif

            case (state)
                IDLE, SPIN: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (at_end) begin
                        pos   <= pos_next;
                        state <= FETCH;
                    end else begin
                        state <= SPIN;
                    end
                end
                // Address already equals the new pos; the buffer returns
                // its byte during LATCH. An access in flight always finishes.
                FETCH: state <= LATCH;
                LATCH: begin
`ifdef DISK_WRITE_EN
                    // The write strobe lands in the cycle after LATCH so a
                    // wr_load arriving during LATCH is still written; pos
                    // cannot move before then.
                    if (wr_mode) begin
                        ram_we  <= 1'b1;
                        ram_din <= wr_load ? wr_data :
                                   (wr_pend ? wr_buf : 8'hFF);
                        wr_pend <= 1'b0;
                        dirty   <= 1'b1;
                    end else begin
                        rd_data <= ram_dout;
                    end
`else
                    rd_data <= ram_dout;
`endif
                    state <= run ? SPIN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
